// File: rtl/l1a_check_scheduler.sv
// ----------------------------------------------------------------------------
// l1a_check_scheduler
//
// Sequences one L1A alignment check per event across the 16 ADCs of the
// LV2 layer-1 front end. Each event opens a one-hot start_check window on
// ADC 0. The window advances on every one_adc_finish_check pulse. The event
// ends with a pass/fail verdict after ADC 15, or with a timeout that
// resynchronises the checker through a two-cycle checker_reset pulse.
//
// Parameters
//   TIMEOUT : cycles allowed waiting on ADC 1..15 before abort (>= 4)
//   CNT_W   : width of the saturating event counters
//
// Ports
//   clk                  system clock, rising edge
//   reset                asynchronous, active-low
//   enable               permits starting a new event check
//   one_adc_finish_check checker pulse: current ADC matched
//   L1A_align            checker pulse: all 16 matched (with final finish)
//   checker_error[15:0]  checker per-ADC mismatch flags
//   start_check[15:0]    one-hot window, bit = current ADC index
//   check_in_progress    high while an event is being checked
//   checker_reset        active-high synchronous reset to the checker
//   busy                 scheduler not idle
//   event_done           1-cycle pulse at the end of every event
//   event_ok             verdict, valid with event_done, held
//   timeout_flag         event aborted on timeout, valid with event_done, held
//   fail_adc[3:0]        ADC at timeout or first mismatch, held
//   event_count          completed events, saturating
//   bad_count            events with event_ok = 0, saturating
// ----------------------------------------------------------------------------
module l1a_check_scheduler #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             one_adc_finish_check,
  input  logic             L1A_align,
  input  logic [15:0]      checker_error,
  output logic [15:0]      start_check,
  output logic             check_in_progress,
  output logic             checker_reset,
  output logic             busy,
  output logic             event_done,
  output logic             event_ok,
  output logic             timeout_flag,
  output logic [3:0]       fail_adc,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] bad_count
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_DONE,
    S_RECOVER
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_idx;
  logic [TW-1:0]    r_wait;
  logic             r_mism;
  logic [3:0]       r_mism_adc;
  logic             r_rec_second;
  logic             r_event_ok;
  logic             r_timeout;
  logic [3:0]       r_fail_adc;
  logic [CNT_W-1:0] r_event_count;
  logic [CNT_W-1:0] r_bad_count;

  logic w_in_check;
  logic w_err_now;
  logic w_finish;
  logic w_last;
  logic w_timeout;
  logic w_mism_any;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_in_check = (r_state == S_CHECK);
  assign w_err_now  = w_in_check & checker_error[r_idx];
  assign w_finish   = w_in_check & one_adc_finish_check;
  assign w_last     = (r_idx == 4'd15);
  // ADC 0 waits indefinitely for the trigger, so it is never timed out.
  // A finish in the same cycle as expiry wins over the timeout.
  assign w_timeout  = w_in_check & ~one_adc_finish_check & (r_idx != 4'd0) &
                      (r_wait == TW'(TIMEOUT - 1));
  // Include a mismatch flagged in the very cycle the verdict is taken.
  assign w_mism_any = r_mism | w_err_now;

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (enable) w_next = S_CHECK;
      S_CHECK: begin
        if (w_finish && w_last) w_next = S_DONE;
        else if (w_timeout)     w_next = S_RECOVER;
      end
      S_DONE:    w_next = S_IDLE;
      S_RECOVER: if (r_rec_second) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    start_check       = '0;
    check_in_progress = 1'b0;
    checker_reset     = 1'b0;
    event_done        = 1'b0;
    unique case (r_state)
      S_CHECK: begin
        start_check       = 16'(1) << r_idx;
        check_in_progress = 1'b1;
      end
      S_DONE:    event_done = 1'b1;
      S_RECOVER: begin
        checker_reset = 1'b1;
        event_done    = r_rec_second;
      end
      default: ;
    endcase
  end

  assign busy         = (r_state != S_IDLE);
  assign event_ok     = r_event_ok;
  assign timeout_flag = r_timeout;
  assign fail_adc     = r_fail_adc;
  assign event_count  = r_event_count;
  assign bad_count    = r_bad_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_wait        <= '0;
      r_mism        <= 1'b0;
      r_mism_adc    <= '0;
      r_rec_second  <= 1'b0;
      r_event_ok    <= 1'b0;
      r_timeout     <= 1'b0;
      r_fail_adc    <= '0;
      r_event_count <= '0;
      r_bad_count   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          r_idx        <= '0;
          r_wait       <= '0;
          r_mism       <= 1'b0;
          r_mism_adc   <= '0;
          r_rec_second <= 1'b0;
        end
        S_CHECK: begin
          if (w_err_now && !r_mism) begin
            r_mism     <= 1'b1;
            r_mism_adc <= r_idx;
          end
          if (w_finish) begin
            if (!w_last) begin
              r_idx  <= r_idx + 4'd1;
              r_wait <= '0;
            end else begin
              // Verdict outputs are published only at event end, so they
              // stay stable between successive event_done pulses.
              r_event_ok <= L1A_align & ~w_mism_any;
              r_timeout  <= 1'b0;
              r_fail_adc <= r_mism ? r_mism_adc : (w_err_now ? r_idx : 4'd0);
            end
          end else if (w_timeout) begin
            r_event_ok <= 1'b0;
            r_timeout  <= 1'b1;
            r_fail_adc <= r_idx;
          end else if (r_idx != 4'd0) begin
            r_wait <= r_wait + TW'(1);
          end
        end
        S_DONE: begin
          r_event_count <= sat_inc(r_event_count);
          if (!r_event_ok) r_bad_count <= sat_inc(r_bad_count);
        end
        S_RECOVER: begin
          r_rec_second <= 1'b1;
          if (r_rec_second) begin
            r_event_count <= sat_inc(r_event_count);
            r_bad_count   <= sat_inc(r_bad_count);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l1a_check_scheduler.sv
// ----------------------------------------------------------------------------
// tb_l1a_check_scheduler
//
// Directed bench for l1a_check_scheduler (TIMEOUT = 16, CNT_W = 4).
// An event-level reference model (current ADC, stall count, end-of-event
// tail) predicts every output; a compare process checks it on each falling
// edge. Directed scenarios add hand-computed literal expectations.
// Inputs change 2 ns after the rising edge; outputs are sampled on the
// falling edge or 2 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_l1a_check_scheduler;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             one_adc_finish_check;
  logic             L1A_align;
  logic [15:0]      checker_error;
  logic [15:0]      start_check;
  logic             check_in_progress;
  logic             checker_reset;
  logic             busy;
  logic             event_done;
  logic             event_ok;
  logic             timeout_flag;
  logic [3:0]       fail_adc;
  logic [CNT_W-1:0] event_count;
  logic [CNT_W-1:0] bad_count;

  int n_chk = 0;
  int n_err = 0;

  l1a_check_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .one_adc_finish_check(one_adc_finish_check),
    .L1A_align           (L1A_align),
    .checker_error       (checker_error),
    .start_check         (start_check),
    .check_in_progress   (check_in_progress),
    .checker_reset       (checker_reset),
    .busy                (busy),
    .event_done          (event_done),
    .event_ok            (event_ok),
    .timeout_flag        (timeout_flag),
    .fail_adc            (fail_adc),
    .event_count         (event_count),
    .bad_count           (bad_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_adc;      // ADC under check, -1 when no event is open
  int m_stall;    // cycles spent waiting on the current ADC
  bit m_mism;
  int m_mism_adc;
  int m_tail_len; // 1: verdict cycle, 2: recovery, 0: none
  int m_tail_pos;
  bit m_ok;
  bit m_to;
  int m_fadc;
  int m_events;
  int m_bad;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_adc = -1; m_stall = 0; m_mism = 0; m_mism_adc = 0;
      m_tail_len = 0; m_tail_pos = 0;
      m_ok = 0; m_to = 0; m_fadc = 0; m_events = 0; m_bad = 0;
    end else if (m_tail_len > 0) begin
      m_tail_pos++;
      if (m_tail_pos == m_tail_len) begin
        m_events++;
        if (!m_ok) m_bad++;
        m_tail_len = 0;
      end
    end else if (m_adc < 0) begin
      if (enable) begin
        m_adc = 0; m_stall = 0; m_mism = 0; m_mism_adc = 0;
      end
    end else begin
      if (checker_error[m_adc] && !m_mism) begin
        m_mism = 1; m_mism_adc = m_adc;
      end
      if (one_adc_finish_check) begin
        if (m_adc < 15) begin
          m_adc++; m_stall = 0;
        end else begin
          m_ok = L1A_align && !m_mism; m_to = 0;
          m_fadc = m_mism ? m_mism_adc : 0;
          m_adc = -1; m_tail_len = 1; m_tail_pos = 0;
        end
      end else if (m_adc > 0) begin
        m_stall++;
        if (m_stall == TIMEOUT) begin
          m_ok = 0; m_to = 1; m_fadc = m_adc;
          m_adc = -1; m_tail_len = 2; m_tail_pos = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("start_check", 32'(start_check), (m_adc >= 0) ? (32'd1 << m_adc) : 32'd0);
    check("check_in_progress", 32'(check_in_progress), 32'(m_adc >= 0));
    check("busy", 32'(busy), 32'(m_adc >= 0 || m_tail_len > 0));
    check("checker_reset", 32'(checker_reset), 32'(m_tail_len == 2));
    check("event_done", 32'(event_done), 32'(m_tail_len > 0 && m_tail_pos == m_tail_len - 1));
    check("event_ok", 32'(event_ok), 32'(m_ok));
    check("timeout_flag", 32'(timeout_flag), 32'(m_to));
    check("fail_adc", 32'(fail_adc), 32'(m_fadc));
    check("event_count", 32'(event_count), 32'((m_events > CMAX) ? CMAX : m_events));
    check("bad_count", 32'(bad_count), 32'((m_bad > CMAX) ? CMAX : m_bad));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_finish(input bit align);
    one_adc_finish_check = 1'b1;
    L1A_align            = align;
    tick();
    one_adc_finish_check = 1'b0;
    L1A_align            = 1'b0;
  endtask

  task automatic start_event();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_wait;
    int n_rst_hi;
    bit seen_done;

    reset = 1'b0; enable = 1'b0; one_adc_finish_check = 1'b0;
    L1A_align = 1'b0; checker_error = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Reset state
    @(negedge clk);
    check("rst start_check", 32'(start_check), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst event_count", 32'(event_count), 32'h0);

    // Good event, enable dropped right after start, finishes 5 cycles apart
    tick();
    start_event();
    @(negedge clk);
    check("first start_check", 32'(start_check), 32'h0001);
    check("first check_in_progress", 32'(check_in_progress), 32'h1);
    check("first event_done", 32'(event_done), 32'h0);
    for (int adc = 0; adc < 16; adc++) begin
      logic [15:0] exp_sc;
      repeat (4) tick();
      exp_sc = 16'h0001 << adc;
      check("walk start_check", 32'(start_check), 32'(exp_sc));
      pulse_finish(adc == 15);
    end
    check("good event_done", 32'(event_done), 32'h1);
    check("good event_ok", 32'(event_ok), 32'h1);
    check("good timeout_flag", 32'(timeout_flag), 32'h0);
    tick();
    check("good event_count", 32'(event_count), 32'h1);
    check("good bad_count", 32'(bad_count), 32'h0);
    check("good busy", 32'(busy), 32'h0);

    // Stray finish in IDLE is ignored
    pulse_finish(1'b1);
    tick();
    check("stray event_count", 32'(event_count), 32'h1);

    // Mismatch on ADC 6 for 3 cycles; L1A_align still asserted at the end
    start_event();
    for (int adc = 0; adc < 16; adc++) begin
      if (adc == 6) begin
        checker_error[6] = 1'b1;
        repeat (3) tick();
        checker_error = '0;
        tick();
      end else begin
        repeat (4) tick();
      end
      pulse_finish(1'b1);
    end
    check("mism event_done", 32'(event_done), 32'h1);
    check("mism event_ok", 32'(event_ok), 32'h0);
    check("mism fail_adc", 32'(fail_adc), 32'h6);
    check("mism timeout_flag", 32'(timeout_flag), 32'h0);
    tick();
    check("mism bad_count", 32'(bad_count), 32'h1);
    check("mism event_count", 32'(event_count), 32'h2);

    // Timeout: no finish for ADC 9
    start_event();
    for (int adc = 0; adc < 9; adc++) begin
      repeat (4) tick();
      pulse_finish(1'b0);
    end
    n_wait = 0; n_rst_hi = 0; seen_done = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (checker_reset) begin
        n_rst_hi++;
        check("recover start_check", 32'(start_check), 32'h0);
        check("recover check_in_progress", 32'(check_in_progress), 32'h0);
      end
      if (event_done) begin
        n_wait = n; seen_done = 1;
        break;
      end
    end
    check("timeout seen", 32'(seen_done), 32'h1);
    check("timeout latency", 32'(n_wait), 32'(TIMEOUT + 2));
    check("timeout checker_reset cycles", 32'(n_rst_hi), 32'h2);
    check("timeout flag", 32'(timeout_flag), 32'h1);
    check("timeout fail_adc", 32'(fail_adc), 32'h9);
    check("timeout event_ok", 32'(event_ok), 32'h0);
    tick();
    check("timeout event_count", 32'(event_count), 32'h3);
    check("timeout bad_count", 32'(bad_count), 32'h2);

    // 20 good events back to back with enable held; event_count saturates
    enable = 1'b1;
    tick();
    for (int ev = 0; ev < 20; ev++) begin
      for (int adc = 0; adc < 16; adc++) begin
        tick();
        pulse_finish(adc == 15);
      end
      if (ev == 19) enable = 1'b0;
      @(negedge clk);
      check("b2b n1 start_check", 32'(start_check), 32'h0);
      @(negedge clk);
      check("b2b n2 start_check", 32'(start_check), 32'h0);
      @(negedge clk);
      check("b2b n3 start_check", 32'(start_check), (ev < 19) ? 32'h0001 : 32'h0);
    end
    check("sat event_count", 32'(event_count), 32'(CMAX));
    check("sat bad_count", 32'(bad_count), 32'h2);

    // Asynchronous reset at ADC 11
    start_event();
    for (int adc = 0; adc < 11; adc++) begin
      repeat (2) tick();
      pulse_finish(1'b0);
    end
    tick();
    check("pre-reset start_check", 32'(start_check), 32'h0800);
    #1 reset = 1'b0;
    #1;
    check("async start_check", 32'(start_check), 32'h0);
    check("async check_in_progress", 32'(check_in_progress), 32'h0);
    check("async busy", 32'(busy), 32'h0);
    check("async checker_reset", 32'(checker_reset), 32'h0);
    check("async event_count", 32'(event_count), 32'h0);
    check("async bad_count", 32'(bad_count), 32'h0);
    check("async flags", 32'({event_ok, timeout_flag, fail_adc}), 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    start_event();
    check("restart start_check", 32'(start_check), 32'h0001);
    for (int adc = 0; adc < 16; adc++) begin
      repeat (2) tick();
      pulse_finish(1'b1);
    end
    tick();
    check("restart event_count", 32'(event_count), 32'h1);
    check("restart event_ok", 32'(event_ok), 32'h1);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/l1a_check_scheduler.md
# l1a_check_scheduler

Sequencer for the 16-ADC L1A alignment checker in the LV2 layer-1 front end. Per event it raises `check_in_progress` and walks a one-hot `start_check` window across ADC 0..15, advancing on the checker's `one_adc_finish_check` pulses. It bounds each per-ADC wait with a timeout and resynchronises the checker by pulsing its reset. It reports per-event outcome plus saturating event and bad-event counters to slow control.

## Interface
Parameters:
- `TIMEOUT`, 4096: cycles allowed waiting on ADC 1..15 before abort (≥4).
- `CNT_W`, 16: width of event counters.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state and outputs.
- `enable`  in  1  permits starting a new event check.
- `one_adc_finish_check`  in  1  checker pulse: current ADC matched.
- `L1A_align`  in  1  checker pulse: all 16 matched, coincident with final finish.
- `checker_error`  in  16  checker per-ADC mismatch flags.
- `start_check`  out  16  one-hot window to checker; bit = current ADC index.
- `check_in_progress`  out  1  high while an event is being checked.
- `checker_reset`  out  1  active-high synchronous reset to checker.
- `busy`  out  1  state ≠ IDLE.
- `event_done`  out  1  1-cycle pulse at end of every event (pass, fail or timeout).
- `event_ok`  out  1  valid with `event_done`; held until next `event_done`.
- `timeout_flag`  out  1  valid with `event_done`; held.
- `fail_adc`  out  4  ADC index at timeout or first mismatch; held.
- `event_count`  out  CNT_W  completed events, saturating.
- `bad_count`  out  CNT_W  events with `event_ok`=0, saturating.

## Operation
- States: IDLE, CHECK, DONE, RECOVER.
- IDLE: `start_check`=0, `check_in_progress`=0. If `enable`=1, go to CHECK next cycle with idx=0.
- CHECK:
  - `check_in_progress`=1, `start_check`=1<<idx.
  - On `one_adc_finish_check`=1 with idx<15: idx+1, clear wait counter.
  - On finish with idx=15: latch `event_ok`=`L1A_align` and go to DONE.
- Mismatch tracking: while in CHECK, if `checker_error[idx]`=1, set sticky `mism` and record `fail_adc`=idx (first one only per event). `event_ok` is forced 0 if `mism` is set.
- Timeout: wait counter runs only for idx≥1; ADC 0 waits indefinitely for trigger. On count = TIMEOUT−1, go to RECOVER with `fail_adc`=idx and `timeout_flag`=1.
- DONE (1 cycle): pulse `event_done`; `event_count`+1; `bad_count`+1 if not ok; then IDLE.
- RECOVER (2 cycles):
  - `checker_reset`=1 and `check_in_progress`=0, `start_check`=0 for both cycles.
  - `event_done` pulses in the second cycle with `event_ok`=0.
  - Both counters +1, then IDLE.
- `enable` deassert mid-event does not abort; the event finishes normally.
- Counters stick at 2^CNT_W−1.
- A finish pulse in IDLE/DONE/RECOVER is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, idx 0, counters 0.
- IDLE→CHECK: 1 cycle after `enable` sampled high.
- `start_check` advances the cycle after finish is sampled. The stale bit for one cycle is harmless because the checker has already moved on.
- Event completion: `event_done` appears 1 cycle after final finish.
- Back-to-back events: with `enable` held high, finish15 → DONE → IDLE → CHECK, so the next `start_check[0]` is 3 cycles after finish15.
- Timeout: `event_done` appears TIMEOUT+2 cycles after entry to the stuck idx.
- Asynchronous reset mid-event: immediate clear. `checker_reset` is not asserted; the checker owns its own reset.

## Test plan
- Reset release, `enable`=1 → `start_check`=16'h0001 and `check_in_progress`=1 one cycle after `enable`; all other outputs 0.
- 16 finish pulses, spaced 5 cycles, `L1A_align`=1 on the 16th → `start_check` walks 0001→8000; `event_done` with `event_ok`=1; `event_count`=1, `bad_count`=0.
- `checker_error[6]`=1 for 3 cycles at idx 6, then finish continues to 15 → `event_ok`=0, `fail_adc`=6, `timeout_flag`=0, `bad_count`=1.
- TIMEOUT=16, no finish after idx 9 → `checker_reset` high 2 cycles; `event_done` with `timeout_flag`=1, `fail_adc`=9; `start_check`=0 during RECOVER.
- CNT_W=4, 20 good events back-to-back → `event_count`=15 (saturated); `start_check[0]` reappears 3 cycles after each final finish.
- `reset` low at idx 11 → all outputs 0 immediately; after release with `enable`=1, a new event restarts at idx 0.
